// File: rtl/ssc_pkg.sv
// Shared FSM state type and default sizing for the selection-sort engine.
package ssc_pkg;

  localparam int SSC_DATA_W = 16;
  localparam int SSC_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SCAN   = 3'd2,
    DRAIN  = 3'd3,
    SWAP_A = 3'd4,
    SWAP_B = 3'd5,
    FIN    = 3'd6
  } ssc_state_t;

endpackage

// File: rtl/ssc_cmp.sv
// Strict, direction-selectable unsigned comparison: better=1 when a should
// displace b as the running extreme (ties keep b, the first occurrence).
module ssc_cmp #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              desc,
  output logic              better
);

  // Unsigned strict compare in the requested direction.
  always_comb begin
    if (desc) begin
      better = (a > b);
    end else begin
      better = (a < b);
    end
  end

endmodule

// File: rtl/ssc_sort_engine.sv
// In-place selection sort over a single-port synchronous RAM; all outputs
// are registered and aligned with the state they belong to.
module ssc_sort_engine
  import ssc_pkg::*;
#(
  parameter int DATA_W = SSC_DATA_W,
  parameter int ADDR_W = SSC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              desc,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] swap_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] TWO = {{(ADDR_W-1){1'b0}}, 2'b10};

  ssc_state_t        state_r, state_nxt;
  logic [ADDR_W:0]   n_r, n_nxt, i_r, i_nxt, j_r, j_nxt;
  logic [ADDR_W:0]   min_addr_r, min_addr_nxt, lag_addr_r;
  logic              lag_load_r, desc_r, desc_nxt;
  logic [DATA_W-1:0] min_r, min_nxt, temp_r, temp_nxt;
  logic [ADDR_W-1:0] swap_cnt_r, swap_cnt_nxt, addr_r, addr_nxt;
  logic              busy_r, busy_nxt, done_r, done_nxt, we_r, we_nxt;
  logic [DATA_W-1:0] wdata_r, wdata_nxt;

  logic [ADDR_W:0]   n_s, n_m1_s, n_m2_s, i_inc_s, j_inc_s;
  logic              better_s;

  assign n_s     = (len > CAP) ? CAP : len;
  assign n_m1_s  = n_r - ONE;
  assign n_m2_s  = n_r - TWO;
  assign i_inc_s = i_r + ONE;
  assign j_inc_s = j_r + ONE;

  ssc_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a      (mem_rdata),
    .b      (min_r),
    .desc   (desc_r),
    .better (better_s)
  );

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_nxt    = state_r;
    n_nxt        = n_r;
    desc_nxt     = desc_r;
    i_nxt        = i_r;
    j_nxt        = j_r;
    min_addr_nxt = min_addr_r;
    min_nxt      = min_r;
    temp_nxt     = temp_r;
    swap_cnt_nxt = swap_cnt_r;
    busy_nxt     = busy_r;
    done_nxt     = 1'b0;
    addr_nxt     = {ADDR_W{1'b0}};
    we_nxt       = 1'b0;
    wdata_nxt    = {DATA_W{1'b0}};

    // Read data lags its address by one cycle; the first word back is element i.
    if ((state_r == SCAN) || (state_r == DRAIN)) begin
      if (lag_load_r) begin
        temp_nxt = mem_rdata;
        min_nxt  = mem_rdata;
      end else if (better_s) begin
        min_nxt      = mem_rdata;
        min_addr_nxt = lag_addr_r;
      end else begin
        min_nxt = min_r;
      end
    end else begin
      min_nxt = min_r;
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          n_nxt        = n_s;
          desc_nxt     = desc;
          swap_cnt_nxt = {ADDR_W{1'b0}};
          i_nxt        = {(ADDR_W+1){1'b0}};
          min_addr_nxt = {(ADDR_W+1){1'b0}};
          if (n_s >= TWO) begin
            state_nxt = LOAD;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = FIN;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        state_nxt = SCAN;
        j_nxt     = i_inc_s;
        addr_nxt  = i_inc_s[ADDR_W-1:0];
      end
      SCAN: begin
        if (j_r == n_m1_s) begin
          state_nxt = DRAIN;
        end else begin
          j_nxt    = j_inc_s;
          addr_nxt = j_inc_s[ADDR_W-1:0];
        end
      end
      DRAIN: begin
        // The final compare lands this cycle, so use the updated min_addr.
        state_nxt = SWAP_A;
        addr_nxt  = min_addr_nxt[ADDR_W-1:0];
        wdata_nxt = temp_r;
        we_nxt    = (min_addr_nxt != i_r);
      end
      SWAP_A: begin
        state_nxt = SWAP_B;
        addr_nxt  = i_r[ADDR_W-1:0];
        wdata_nxt = min_r;
        we_nxt    = (min_addr_r != i_r);
        if (min_addr_r != i_r) begin
          swap_cnt_nxt = swap_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          swap_cnt_nxt = swap_cnt_r;
        end
      end
      SWAP_B: begin
        if (i_r == n_m2_s) begin
          state_nxt = FIN;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          state_nxt    = LOAD;
          i_nxt        = i_inc_s;
          min_addr_nxt = i_inc_s;
          addr_nxt     = i_inc_s[ADDR_W-1:0];
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      n_r        <= {(ADDR_W+1){1'b0}};
      desc_r     <= 1'b0;
      i_r        <= {(ADDR_W+1){1'b0}};
      j_r        <= {(ADDR_W+1){1'b0}};
      min_addr_r <= {(ADDR_W+1){1'b0}};
      lag_addr_r <= {(ADDR_W+1){1'b0}};
      lag_load_r <= 1'b0;
      min_r      <= {DATA_W{1'b0}};
      temp_r     <= {DATA_W{1'b0}};
      swap_cnt_r <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      we_r       <= 1'b0;
      wdata_r    <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_nxt;
      n_r        <= n_nxt;
      desc_r     <= desc_nxt;
      i_r        <= i_nxt;
      j_r        <= j_nxt;
      min_addr_r <= min_addr_nxt;
      lag_addr_r <= {1'b0, addr_r};
      lag_load_r <= (state_r == LOAD);
      min_r      <= min_nxt;
      temp_r     <= temp_nxt;
      swap_cnt_r <= swap_cnt_nxt;
      busy_r     <= busy_nxt;
      done_r     <= done_nxt;
      addr_r     <= addr_nxt;
      we_r       <= we_nxt;
      wdata_r    <= wdata_nxt;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign swap_cnt  = swap_cnt_r;
  assign mem_addr  = addr_r;
  assign mem_we    = we_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_ssc_sort_engine.sv
// Directed self-checking bench for ssc_sort_engine with a behavioural
// single-port synchronous RAM.
module tb_ssc_sort_engine;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int LIMIT  = 40000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              desc;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] swap_cnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ram      [DEPTH];
  logic [DATA_W-1:0] init_ram [DEPTH];
  logic              ram_load;
  int                wr_cnt;
  int                errors;
  int                checks;

  ssc_sort_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .desc      (desc),
    .busy      (busy),
    .done      (done),
    .swap_cnt  (swap_cnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model with a bulk preload path and a write counter.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int k = 0; k < DEPTH; k++) ram[k] <= init_ram[k];
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic load_ram;
    @(negedge clk); ram_load = 1'b1;
    @(negedge clk); ram_load = 1'b0;
  endtask

  task automatic set4(input logic [15:0] a, b, c, d);
    init_ram[0] = a; init_ram[1] = b; init_ram[2] = c; init_ram[3] = d;
    load_ram();
  endtask

  // Start a sort and count cycles from the sampling edge to done.
  task automatic do_sort(input logic [ADDR_W:0] l, input logic d, output int cyc);
    @(negedge clk); len = l; desc = d; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    while (!done && cyc < LIMIT) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; len = '0; desc = 1'b0; ram_load = 1'b0; wr_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, mem_we} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got busy/done/we=%b expected 000", {busy, done, mem_we});
    end
    checks++;
    if (swap_cnt !== 8'd0 || mem_addr !== 8'd0 || mem_wdata !== 16'd0) begin
      errors++; $display("FAIL reset_regs: got cnt=%0d addr=%0d wdata=%h expected 0", swap_cnt, mem_addr, mem_wdata);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    int cyc, w0;
    logic [15:0] exp4 [4];
    exp4[0] = 16'd0; exp4[1] = 16'd1; exp4[2] = 16'd2; exp4[3] = 16'd3;
    set4(16'd3, 16'd1, 16'd2, 16'd0);
    w0 = wr_cnt;
    do_sort(9'd4, 1'b0, cyc);
    checks++;
    if (cyc !== 19) begin errors++; $display("FAIL basic_cycles: got %0d expected 19", cyc); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ram[k] !== exp4[k]) begin errors++; $display("FAIL basic_ram[%0d]: got %h expected %h", k, ram[k], exp4[k]); end
    end
    checks++;
    if (swap_cnt !== 8'd1) begin errors++; $display("FAIL basic_swaps: got %0d expected 1", swap_cnt); end
    checks++;
    if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL basic_writes: got %0d expected 2", wr_cnt - w0); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (swap_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_hold: got cnt=%0d busy=%b expected 1/0", swap_cnt, busy);
    end
  endtask

  task automatic test_desc_ties;
    int cyc, w0;
    logic [15:0] exp4 [4];
    exp4[0] = 16'd9; exp4[1] = 16'd5; exp4[2] = 16'd5; exp4[3] = 16'd1;
    set4(16'd5, 16'd5, 16'd1, 16'd9);
    w0 = wr_cnt;
    do_sort(9'd4, 1'b1, cyc);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ram[k] !== exp4[k]) begin errors++; $display("FAIL desc_ram[%0d]: got %h expected %h", k, ram[k], exp4[k]); end
    end
    checks++;
    if (swap_cnt !== 8'd2) begin errors++; $display("FAIL desc_swaps: got %0d expected 2", swap_cnt); end
    checks++;
    if (wr_cnt - w0 !== 4) begin errors++; $display("FAIL desc_writes: got %0d expected 4", wr_cnt - w0); end
    checks++;
    if (cyc !== 19) begin errors++; $display("FAIL desc_cycles: got %0d expected 19", cyc); end
  endtask

  task automatic test_short;
    int cyc, w0;
    logic [ADDR_W:0] lens [2];
    lens[0] = 9'd1; lens[1] = 9'd0;
    set4(16'd7, 16'd6, 16'd5, 16'd4);
    for (int t = 0; t < 2; t++) begin
      w0 = wr_cnt;
      do_sort(lens[t], 1'b0, cyc);
      checks++;
      if (cyc !== 1) begin errors++; $display("FAIL short_cycles len=%0d: got %0d expected 1", lens[t], cyc); end
      checks++;
      if (wr_cnt !== w0) begin errors++; $display("FAIL short_writes len=%0d: got %0d expected 0", lens[t], wr_cnt - w0); end
      checks++;
      if (swap_cnt !== 8'd0) begin errors++; $display("FAIL short_swaps len=%0d: got %0d expected 0", lens[t], swap_cnt); end
      checks++;
      if (ram[0] !== 16'd7 || ram[3] !== 16'd4) begin
        errors++; $display("FAIL short_ram len=%0d: got %h/%h expected 0007/0004", lens[t], ram[0], ram[3]);
      end
    end
  endtask

  task automatic test_full;
    logic [15:0] ref_a [DEPTH];
    logic [15:0] tmp;
    int cyc, j, bad;
    for (int k = 0; k < DEPTH; k++) begin
      init_ram[k] = 16'($urandom);
      ref_a[k]    = init_ram[k];
    end
    init_ram[5] = 16'hFFFF; ref_a[5] = 16'hFFFF;
    init_ram[9] = 16'h0000; ref_a[9] = 16'h0000;
    for (int k = 1; k < DEPTH; k++) begin
      tmp = ref_a[k]; j = k - 1;
      while (j >= 0 && ref_a[j] > tmp) begin ref_a[j+1] = ref_a[j]; j--; end
      ref_a[j+1] = tmp;
    end
    load_ram();
    @(negedge clk); len = 9'd256; desc = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    while (!done && cyc < LIMIT) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 100) begin start = 1'b1; len = 9'd3; desc = 1'b1; end
      else if (cyc == 101) start = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (cyc !== 33661) begin errors++; $display("FAIL full_cycles: got %0d expected 33661", cyc); end
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ram[k] !== ref_a[k]) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_contents: got %0d differing words expected 0", bad); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    set4(16'd4, 16'd3, 16'd2, 16'd1);
    @(negedge clk); len = 9'd4; desc = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    while (cyc < 12) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'd2) begin
      errors++; $display("FAIL mid_swapa: got we=%b addr=%0d expected 1/2", mem_we, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got busy=%b we=%b expected 0/0", busy, mem_we);
    end
    @(negedge clk); rst = 1'b0;
    checks++;
    if (ram[1] !== 16'd3 || ram[2] !== 16'd2) begin
      errors++; $display("FAIL mid_partial: got %h/%h expected 0003/0002", ram[1], ram[2]);
    end
    do_sort(9'd4, 1'b0, cyc);
    checks++;
    if (ram[0] !== 16'd1 || ram[1] !== 16'd2 || ram[2] !== 16'd3 || ram[3] !== 16'd4) begin
      errors++; $display("FAIL mid_resort: got %h %h %h %h expected 1 2 3 4", ram[0], ram[1], ram[2], ram[3]);
    end
    checks++;
    if (swap_cnt !== 8'd1 || cyc !== 19) begin
      errors++; $display("FAIL mid_resort_cnt: got cnt=%0d cyc=%0d expected 1/19", swap_cnt, cyc);
    end
  endtask

  task automatic test_extremes;
    int cyc;
    set4(16'hFFFF, 16'h0000, 16'h8000, 16'h0001);
    do_sort(9'd4, 1'b0, cyc);
    checks++;
    if (ram[0] !== 16'h0000 || ram[1] !== 16'h0001 || ram[2] !== 16'h8000 || ram[3] !== 16'hFFFF) begin
      errors++; $display("FAIL ext_asc: got %h %h %h %h expected 0000 0001 8000 ffff", ram[0], ram[1], ram[2], ram[3]);
    end
    checks++;
    if (swap_cnt !== 8'd2) begin errors++; $display("FAIL ext_asc_swaps: got %0d expected 2", swap_cnt); end
    set4(16'h0001, 16'h8000, 16'h0000, 16'hFFFF);
    do_sort(9'd4, 1'b1, cyc);
    checks++;
    if (ram[0] !== 16'hFFFF || ram[1] !== 16'h8000 || ram[2] !== 16'h0001 || ram[3] !== 16'h0000) begin
      errors++; $display("FAIL ext_desc: got %h %h %h %h expected ffff 8000 0001 0000", ram[0], ram[1], ram[2], ram[3]);
    end
    checks++;
    if (swap_cnt !== 8'd2) begin errors++; $display("FAIL ext_desc_swaps: got %0d expected 2", swap_cnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_desc_ties();
    test_short();
    test_extremes();
    test_reset_mid();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
